// File: rtl/symbol_lock_ctrl.sv
// symbol_lock_ctrl: K28.5 comma search over all ten bit offsets, lock
// qualification and aligned-symbol presentation for one receive lane.
module symbol_lock_ctrl #(
  parameter int LOCK_COMMAS = 4,     // consecutive commas at one offset to lock
  parameter int UNLOCK_BAD  = 4,     // consecutive misaligned commas to unlock
  parameter int TIMEOUT     = 1024,  // valid words without a comma to unlock
  parameter int GAP_W       = 11     // gap counter width, 2^GAP_W > TIMEOUT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] RawIn,
  input  logic       RawValid,
  input  logic       ForceHunt,
  output logic [9:0] AlignedSym,
  output logic       AlignValid,
  output logic       Locked,
  output logic [3:0] Offset,
  output logic       CommaDet,
  output logic       LockLost
);

  localparam logic [9:0]       COMMA_RDN = 10'h17C;
  localparam logic [9:0]       COMMA_RDP = 10'h283;
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_COMMAS);
  localparam logic [3:0]       UNLOCK_N  = 4'(UNLOCK_BAD);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_reg;
  logic [9:0]       prev_reg;
  logic [3:0]       offset_reg;
  logic [3:0]       comma_cnt_reg;
  logic [3:0]       bad_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [9:0]       aligned_reg;
  logic             align_valid_reg;
  logic             locked_reg;
  logic             comma_det_reg;
  logic             lock_lost_reg;

  // Two-word history: previous word in the low half (earlier bits),
  // current word in the high half.
  logic [19:0]      hist;
  logic [9:0]       cand [10];
  logic [9:0]       match_vec;
  logic             any_match;
  logic             match_at_off;
  logic [3:0]       low_idx;
  logic [GAP_W-1:0] gap_next;
  logic             gap_hit;
  logic             lock_drop;

  assign hist = {RawIn, prev_reg};

  for (genvar gi = 0; gi < 10; gi++) begin : g_cand
    assign cand[gi]      = hist[gi+9:gi];
    assign match_vec[gi] = RawValid && ((cand[gi] == COMMA_RDN) || (cand[gi] == COMMA_RDP));
  end

  assign any_match    = |match_vec;
  assign match_at_off = match_vec[offset_reg];

  // Lowest matching offset wins when commas appear at several offsets.
  always_comb begin
    low_idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (match_vec[i]) low_idx = 4'(i);
    end
  end

  // Saturating gap count and the loss-of-lock decision while locked.
  always_comb begin
    gap_next  = (gap_cnt_reg == GAP_MAX) ? GAP_MAX : gap_cnt_reg + 1'b1;
    gap_hit   = (gap_next == GAP_MAX);
    lock_drop = !match_at_off &&
                ((any_match && ((bad_cnt_reg + 4'd1) == UNLOCK_N)) || gap_hit);
  end

  // Lock FSM, counters, history and registered datapath outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= ST_HUNT;
      prev_reg        <= '0;
      offset_reg      <= '0;
      comma_cnt_reg   <= '0;
      bad_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
      aligned_reg     <= '0;
      align_valid_reg <= 1'b0;
      locked_reg      <= 1'b0;
      comma_det_reg   <= 1'b0;
      lock_lost_reg   <= 1'b0;
    end else begin
      align_valid_reg <= 1'b0;
      comma_det_reg   <= 1'b0;
      lock_lost_reg   <= 1'b0;

      // Datapath uses the offset and lock state from before this update.
      if (RawValid) begin
        prev_reg        <= RawIn;
        aligned_reg     <= cand[offset_reg];
        align_valid_reg <= locked_reg;
        comma_det_reg   <= match_at_off;
      end

      if (ForceHunt) begin
        // Offset is intentionally kept so a re-hunt starts from a known value.
        state_reg     <= ST_HUNT;
        locked_reg    <= 1'b0;
        lock_lost_reg <= locked_reg;
        comma_cnt_reg <= '0;
        bad_cnt_reg   <= '0;
        gap_cnt_reg   <= '0;
      end else if (RawValid) begin
        gap_cnt_reg <= match_at_off ? '0 : gap_next;
        case (state_reg)
          ST_HUNT: begin
            if (any_match) begin
              offset_reg    <= low_idx;
              comma_cnt_reg <= 4'd1;
              gap_cnt_reg   <= '0;
              if (LOCK_N == 4'd1) begin
                state_reg   <= ST_LOCKED;
                locked_reg  <= 1'b1;
                bad_cnt_reg <= '0;
              end else begin
                state_reg <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (match_at_off) begin
              comma_cnt_reg <= comma_cnt_reg + 4'd1;
              if ((comma_cnt_reg + 4'd1) == LOCK_N) begin
                state_reg   <= ST_LOCKED;
                locked_reg  <= 1'b1;
                bad_cnt_reg <= '0;
              end
            end else if (any_match) begin
              // Comma moved: restart qualification at the new offset.
              offset_reg    <= low_idx;
              comma_cnt_reg <= 4'd1;
              gap_cnt_reg   <= '0;
            end else if (gap_hit) begin
              state_reg     <= ST_HUNT;
              comma_cnt_reg <= '0;
              gap_cnt_reg   <= '0;
            end
          end
          ST_LOCKED: begin
            if (match_at_off) begin
              bad_cnt_reg <= '0;
            end else if (any_match) begin
              bad_cnt_reg <= bad_cnt_reg + 4'd1;
            end
            if (lock_drop) begin
              state_reg     <= ST_HUNT;
              locked_reg    <= 1'b0;
              lock_lost_reg <= 1'b1;
              comma_cnt_reg <= '0;
              bad_cnt_reg   <= '0;
              gap_cnt_reg   <= '0;
            end
          end
          default: begin
            state_reg  <= ST_HUNT;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign AlignedSym = aligned_reg;
  assign AlignValid = align_valid_reg;
  assign Locked     = locked_reg;
  assign Offset     = offset_reg;
  assign CommaDet   = comma_det_reg;
  assign LockLost   = lock_lost_reg;

endmodule

// File: tb/tb_symbol_lock_ctrl.sv
// tb_symbol_lock_ctrl: bit-stream driven bench for symbol_lock_ctrl. Symbols
// are packed LSB-first into a serial bit queue (optionally shifted), chopped
// into 10-bit words, and every comma's stream position is recorded so the
// bench knows on which word and at which offset it must be detected.
module tb_symbol_lock_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] RawIn;
  logic       RawValid;
  logic       ForceHunt;
  logic [9:0] AlignedSym;
  logic       AlignValid;
  logic       Locked;
  logic [3:0] Offset;
  logic       CommaDet;
  logic       LockLost;

  int tests = 0;
  int fails = 0;

  bit         bq[$];         // serial bits not yet sent
  int         comma_pos[$];  // stream bit position of each comma start
  logic [19:0] h_q[$];       // scoreboard: {word, previous word} per valid word
  logic [9:0] prev_w;
  int         bits_total;
  int         words_sent;

  symbol_lock_ctrl #(
    .LOCK_COMMAS(4), .UNLOCK_BAD(4), .TIMEOUT(1024), .GAP_W(11)
  ) dut (
    .Clk(Clk), .Reset(Reset), .RawIn(RawIn), .RawValid(RawValid),
    .ForceHunt(ForceHunt), .AlignedSym(AlignedSym), .AlignValid(AlignValid),
    .Locked(Locked), .Offset(Offset), .CommaDet(CommaDet), .LockLost(LockLost)
  );

  // 100 MHz clock
  always #5 Clk = ~Clk;

  function automatic logic [9:0] filler();
    if ($urandom_range(0, 1) == 0) return 10'h2AA;
    return 10'h155;
  endfunction

  function automatic logic [9:0] cand_of(input logic [19:0] h, input int k);
    logic [19:0] t;
    t = h >> k;
    return t[9:0];
  endfunction

  task automatic do_reset();
    Reset = 1'b1; RawValid = 1'b0; ForceHunt = 1'b0; RawIn = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    bq.delete(); comma_pos.delete(); h_q.delete();
    prev_w = '0; bits_total = 0; words_sent = 0;
  endtask

  task automatic push_bits(input logic [9:0] v, input int n);
    for (int b = 0; b < n; b++) bq.push_back(v[b]);
    bits_total += n;
  endtask

  task automatic push_sym(input logic [9:0] sym, input bit is_comma);
    if (is_comma) comma_pos.push_back(bits_total);
    push_bits(sym, 10);
  endtask

  // Sends the next 10 queued bits as one valid word; reports whether a comma
  // becomes fully visible (detectable) with this word and at which offset.
  task automatic send_next(input bit fh, output bit det, output int det_off);
    logic [9:0] w;
    for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
    det = 1'b0; det_off = 0;
    if (comma_pos.size() > 0 && comma_pos[0] < 10 * words_sent) begin
      det = 1'b1;
      det_off = comma_pos[0] % 10;
      void'(comma_pos.pop_front());
    end
    h_q.push_back({w, prev_w});
    prev_w = w;
    RawIn = w; RawValid = 1'b1; ForceHunt = fh;
    @(posedge Clk);
    #1;
    RawValid = 1'b0; ForceHunt = 1'b0;
    words_sent++;
  endtask

  task automatic idle_cycle();
    RawValid = 1'b0;
    RawIn = 10'($urandom);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({AlignedSym, AlignValid, Locked, Offset, CommaDet, LockLost} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs: got sym=%h av=%b lk=%b off=%0d cd=%b ll=%b want all 0",
               AlignedSym, AlignValid, Locked, Offset, CommaDet, LockLost);
    end
  endtask

  task automatic test_lock(input int s);
    bit det; int doff; int ndet; int exp_off; bit exp_lock; bit exp_av; bit alt;
    logic [19:0] hv; logic [9:0] exp_sym;
    ndet = 0; exp_off = 0; exp_lock = 1'b0; alt = 1'b0;
    do_reset();
    if (s > 0) push_bits(10'h2AA >> (10 - s), s);
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        push_sym(alt ? 10'h283 : 10'h17C, 1'b1);
        alt = !alt;
      end else push_sym(filler(), 1'b0);
    end
    while (bq.size() >= 10) begin
      exp_av = exp_lock;
      send_next(1'b0, det, doff);
      hv = h_q.pop_front();
      tests++;
      if (CommaDet !== (det && (doff == exp_off))) begin
        fails++;
        $display("FAIL lock%0d_commadet word %0d: got %b want %b", s, words_sent, CommaDet, det && (doff == exp_off));
      end
      if (det) begin ndet++; exp_off = doff; end
      exp_lock = (ndet >= 4);
      tests++;
      if (Locked !== exp_lock) begin
        fails++;
        $display("FAIL lock%0d_locked word %0d: got %b want %b", s, words_sent, Locked, exp_lock);
      end
      tests++;
      if (AlignValid !== exp_av) begin
        fails++;
        $display("FAIL lock%0d_alignvalid word %0d: got %b want %b", s, words_sent, AlignValid, exp_av);
      end
      if (exp_av) begin
        exp_sym = cand_of(hv, s);
        tests++;
        if (AlignedSym !== exp_sym) begin
          fails++;
          $display("FAIL lock%0d_sym word %0d: got %h want %h", s, words_sent, AlignedSym, exp_sym);
        end
      end
      if (exp_lock) begin
        tests++;
        if (Offset !== 4'(s)) begin
          fails++;
          $display("FAIL lock%0d_offset: got %0d want %0d", s, Offset, s);
        end
      end
      tests++;
      if (LockLost !== 1'b0) begin
        fails++;
        $display("FAIL lock%0d_locklost word %0d: got %b want 0", s, words_sent, LockLost);
      end
    end
  endtask

  task automatic test_reseed();
    bit det; int doff; int n5; int ndet; int exp_off; bit exp_lock;
    n5 = 0; ndet = 0; exp_off = 0;
    do_reset();
    push_bits(10'h2AA >> 7, 3);
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 7) push_sym(10'h17C, 1'b1);
      else push_sym(filler(), 1'b0);
    end
    push_sym(10'h2AA, 1'b0);
    push_bits(10'b10, 2);  // slip the stream by two bits: offset 3 -> 5
    for (int i = 0; i < 22; i++) begin
      if (i % 4 == 3 && i < 20) push_sym((i % 8 == 3) ? 10'h283 : 10'h17C, 1'b1);
      else push_sym(filler(), 1'b0);
    end
    while (bq.size() >= 10) begin
      send_next(1'b0, det, doff);
      if (det) begin
        ndet++;
        exp_off = doff;
        if (doff == 5) n5++;
      end
      exp_lock = (n5 >= 4);
      tests++;
      if (Locked !== exp_lock) begin
        fails++;
        $display("FAIL reseed_locked word %0d: got %b want %b (commas at 5: %0d)", words_sent, Locked, exp_lock, n5);
      end
      if (ndet > 0) begin
        tests++;
        if (Offset !== 4'(exp_off)) begin
          fails++;
          $display("FAIL reseed_offset word %0d: got %0d want %0d", words_sent, Offset, exp_off);
        end
      end
    end
  endtask

  task automatic test_misalign();
    bit det; int doff; int n2; int n6; int ll_cnt; bit exp_lock; bit exp_ll;
    n2 = 0; n6 = 0; ll_cnt = 0;
    do_reset();
    push_bits(10'h2AA >> 8, 2);
    for (int i = 0; i < 32; i++) begin
      if (i % 8 == 7) push_sym(10'h17C, 1'b1);
      else push_sym(filler(), 1'b0);
    end
    push_sym(10'h2AA, 1'b0);
    push_bits(10'b1010, 4);  // slip by four bits: offset 2 -> 6
    for (int i = 0; i < 48; i++) begin
      if (i % 8 == 7) push_sym(10'h283, 1'b1);
      else push_sym(filler(), 1'b0);
    end
    while (bq.size() >= 10) begin
      send_next(1'b0, det, doff);
      if (det) begin
        if (doff == 2) n2++;
        else n6++;
      end
      exp_lock = (n2 >= 4) && (n6 < 4);
      exp_ll   = det && (doff == 6) && (n6 == 4);
      if (LockLost === 1'b1) ll_cnt++;
      tests++;
      if (Locked !== exp_lock) begin
        fails++;
        $display("FAIL misalign_locked word %0d: got %b want %b", words_sent, Locked, exp_lock);
      end
      tests++;
      if (LockLost !== exp_ll) begin
        fails++;
        $display("FAIL misalign_locklost word %0d: got %b want %b", words_sent, LockLost, exp_ll);
      end
      if (exp_lock) begin
        tests++;
        if (Offset !== 4'd2) begin
          fails++;
          $display("FAIL misalign_offset_held: got %0d want 2", Offset);
        end
      end
      if (det && n6 == 5) begin
        tests++;
        if (Offset !== 4'd6) begin
          fails++;
          $display("FAIL misalign_rehunt_offset: got %0d want 6", Offset);
        end
      end
    end
    tests++;
    if (ll_cnt != 1) begin
      fails++;
      $display("FAIL misalign_locklost_count: got %0d want 1", ll_cnt);
    end
  endtask

  task automatic test_timeout();
    bit det; int doff; int ndet; int cnt; int n; bit exp_lock; bit exp_av; bit alt;
    logic [19:0] hv; logic [9:0] exp_sym;
    ndet = 0; cnt = 0; exp_lock = 1'b0; alt = 1'b0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i % 8 == 7) begin
        push_sym(alt ? 10'h283 : 10'h17C, 1'b1);
        alt = !alt;
      end else push_sym(filler(), 1'b0);
    end
    while (bq.size() >= 10) begin
      send_next(1'b0, det, doff);
      void'(h_q.pop_front());
      if (det) ndet++;
    end
    for (int it = 0; it < 1100 && cnt < 1026; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 3);
        repeat (n) idle_cycle();
        tests++;
        if (AlignValid !== 1'b0 || CommaDet !== 1'b0) begin
          fails++;
          $display("FAIL timeout_idle_strobes: got av=%b cd=%b want 0 0", AlignValid, CommaDet);
        end
        tests++;
        if (Locked !== exp_lock) begin
          fails++;
          $display("FAIL timeout_idle_locked gap %0d: got %b want %b", cnt, Locked, exp_lock);
        end
      end
      push_sym(filler(), 1'b0);
      exp_av = exp_lock;
      send_next(1'b0, det, doff);
      hv = h_q.pop_front();
      if (det) begin ndet++; cnt = 0; end
      else if (ndet >= 4) cnt++;
      exp_lock = (ndet >= 4) && (cnt < 1024);
      tests++;
      if (Locked !== exp_lock) begin
        fails++;
        $display("FAIL timeout_locked gap %0d: got %b want %b", cnt, Locked, exp_lock);
      end
      tests++;
      if (LockLost !== (cnt == 1024)) begin
        fails++;
        $display("FAIL timeout_locklost gap %0d: got %b want %b", cnt, LockLost, cnt == 1024);
      end
      if (exp_av) begin
        exp_sym = cand_of(hv, 0);
        tests++;
        if (AlignedSym !== exp_sym) begin
          fails++;
          $display("FAIL timeout_sym gap %0d: got %h want %h", cnt, AlignedSym, exp_sym);
        end
      end
    end
  endtask

  task automatic test_forcehunt();
    bit det; int doff; int ndet; bit fh; bit next_det; bit alt;
    // ForceHunt coincident with the qualifying comma
    ndet = 0; alt = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        push_sym(alt ? 10'h283 : 10'h17C, 1'b1);
        alt = !alt;
      end else push_sym(filler(), 1'b0);
    end
    while (bq.size() >= 10) begin
      next_det = (comma_pos.size() > 0) && (comma_pos[0] < 10 * words_sent);
      fh = next_det && (ndet == 3);
      send_next(fh, det, doff);
      if (det) ndet++;
      tests++;
      if (Locked !== 1'b0 || LockLost !== 1'b0) begin
        fails++;
        $display("FAIL forcehunt_qualify word %0d: got lk=%b ll=%b want 0 0", words_sent, Locked, LockLost);
      end
    end
    // ForceHunt while locked at offset 4, with no valid word that cycle
    do_reset();
    push_bits(10'h2AA >> 6, 4);
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) push_sym(10'h17C, 1'b1);
      else push_sym(filler(), 1'b0);
    end
    while (bq.size() >= 10) send_next(1'b0, det, doff);
    tests++;
    if (Locked !== 1'b1 || Offset !== 4'd4) begin
      fails++;
      $display("FAIL forcehunt_prelock: got lk=%b off=%0d want 1 4", Locked, Offset);
    end
    ForceHunt = 1'b1;
    @(posedge Clk);
    #1;
    ForceHunt = 1'b0;
    tests++;
    if (Locked !== 1'b0 || LockLost !== 1'b1 || Offset !== 4'd4) begin
      fails++;
      $display("FAIL forcehunt_exit: got lk=%b ll=%b off=%0d want 0 1 4", Locked, LockLost, Offset);
    end
    idle_cycle();
    tests++;
    if (LockLost !== 1'b0) begin
      fails++;
      $display("FAIL forcehunt_pulse_width: got %b want 0", LockLost);
    end
    // Relock, then reset together with a valid comma word
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) push_sym(10'h283, 1'b1);
      else push_sym(filler(), 1'b0);
    end
    while (bq.size() >= 10) send_next(1'b0, det, doff);
    tests++;
    if (Locked !== 1'b1) begin
      fails++;
      $display("FAIL forcehunt_relock: got %b want 1", Locked);
    end
    Reset = 1'b1; RawValid = 1'b1; RawIn = 10'h17C;
    @(posedge Clk);
    #1;
    Reset = 1'b0; RawValid = 1'b0;
    tests++;
    if ({AlignedSym, AlignValid, Locked, Offset, CommaDet, LockLost} !== 18'd0) begin
      fails++;
      $display("FAIL reset_while_locked: got sym=%h av=%b lk=%b off=%0d cd=%b ll=%b want all 0",
               AlignedSym, AlignValid, Locked, Offset, CommaDet, LockLost);
    end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_lock(0);
    test_lock(7);
    test_reseed();
    test_misalign();
    test_timeout();
    test_forcehunt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
